uart_stream_arbiter: RTL and testbench
======================================

Name: uart_stream_arbiter

Overview:
- Shares the single UART transmitter byte input between NUM_SRC byte-stream requesters, e.g. raw QRNG bytes and health/telemetry bytes.
- Grants one source at a time in round-robin order and sends a fixed-length framed burst: a header byte, then BURST_LEN payload bytes.
- The PC side can demultiplex streams by header.
- Sits between the producers and the transmitter's circular buffer; tx_ready is driven from the transmitter's buffer-not-full condition.

Parameters:
- NUM_SRC, 2, number of requesters (1..4).
- BURST_LEN, 16, payload bytes per burst (1..255).
- HDR_MAGIC, 4'hA, upper nibble of every header byte.

Ports:
- clk  in  1  system clock (48 MHz domain).
- rst_n  in  1  synchronous active-low reset; sampled on posedge clk.
- src_data  in  8*NUM_SRC  byte from source i on bits [8i+7:8i].
- src_valid  in  NUM_SRC  source i has a byte.
- src_ready  out  NUM_SRC  byte of source i consumed this cycle.
- tx_data  out  8  byte to transmitter.
- tx_valid  out  1  tx_data valid; a transfer occurs when tx_valid && tx_ready.
- tx_ready  in  1  transmitter can accept a byte (its buffer is not full).
- grant_id  out  2  currently/last granted source.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Handshakes:
  - Transfer = valid && ready at posedge clk.
  - src_ready[i] = (state==PAYLOAD) && (grant_id==i) && tx_ready; all other bits 0.
  - src_ready never depends on src_valid.
- Reset (rst_n==0 at posedge): state=IDLE, tx_valid=0, src_ready=0, grant_id=0, rr_ptr=0, byte_cnt=0, checksum=0, busy=0.
  - Reset mid-burst abandons the burst; no trailer is sent.
- FSM states: IDLE, HEADER, PAYLOAD, TRAILER (TRAILER exists only with the optional feature).
- IDLE:
  - If any src_valid is set, pick the first requesting index at or after rr_ptr, wrapping modulo NUM_SRC.
  - Register it into grant_id and go to HEADER next cycle.
  - tx_valid=0.
  - Arbitration takes 1 cycle.
- HEADER:
  - tx_valid=1, tx_data={HDR_MAGIC, 2'b00, grant_id}; registered output, stable until accepted.
  - On transfer: byte_cnt=0, go to PAYLOAD.
- PAYLOAD:
  - tx_valid=src_valid[grant_id], tx_data=src_data[grant_id]; combinational pass-through, zero latency.
  - Each transfer increments byte_cnt.
  - When the transfer with byte_cnt==BURST_LEN-1 occurs, go to TRAILER (feature on) or to IDLE (feature off).
  - If the source drops valid, the burst stalls; no timeout, no byte is skipped, and no other source is granted.
- End of burst: rr_ptr = grant_id+1 mod NUM_SRC, so the granted source gets lowest priority next time.
- Throughput: at most one byte per cycle when tx_ready and src_valid are held high.
  - Back-to-back bursts from the same source are separated by exactly 1 IDLE cycle.
- Width rules:
  - byte_cnt is 8 bits.
  - grant_id is zero-extended to 2 bits.
  - Header bits [3:2] are always 0.
- Simultaneous requests: resolved by rr_ptr only; requests arriving mid-burst wait.
- tx_ready low: holds all outputs and state; header/trailer bytes are neither lost nor duplicated.
- NUM_SRC==1: always grants source 0; the header is still sent.

Optional Feature:
- Macro UART_ARB_CHECKSUM_EN.
- Defined:
  - checksum register cleared on HEADER transfer; XOR of every payload byte accepted.
  - TRAILER state drives tx_valid=1, tx_data=checksum; on transfer go to IDLE.
  - Frame length is BURST_LEN+2 bytes.
- Undefined: no TRAILER state and no checksum register; frame length is BURST_LEN+1 bytes.

Decomposition:
- Package uart_arb_pkg holds:
  - FSM state enum (IDLE, HEADER, PAYLOAD, TRAILER).
  - HDR_MAGIC default.
  - Header-field layout constants (magic [7:4], id [1:0]).
- One sub-module is natural: rr_picker, a combinational round-robin selector.
  - Inputs: req vector and rr_ptr.
  - Outputs: winner index and any_req.
- The FSM stays in the top module.

Test Plan:
- Reset while in PAYLOAD with byte_cnt=5 -> next cycle tx_valid=0, busy=0, grant_id=0; the next burst starts with a fresh header and no trailer.
- Source 1 only, BURST_LEN=4, bytes 01,02,03,04, tx_ready=1 -> tx stream A1,01,02,03,04 (plus trailer 04 with checksum on; 01^02^03^04=04); src_ready[0] stays 0.
- Both sources always valid, rr_ptr=0 -> headers alternate A0, A1, A0, ...; each burst has exactly BURST_LEN payload bytes from the matching source.
- tx_ready toggles 1/0 every cycle during header and payload -> each byte is transferred exactly once; tx_data is stable while tx_valid && !tx_ready.
- Granted source drops src_valid for 10 cycles mid-burst while the other source is valid -> no src_ready to the other source; the burst resumes and completes with the correct count.
- NUM_SRC=1, source continuously valid -> A0 header every BURST_LEN+1 (or +2 with checksum) transfers plus 1 idle cycle.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and header layout for the UART stream arbiter.
// FSM state encoding, default header magic and header field positions.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    TRAILER
  } arb_state_e;

  localparam logic [3:0] HDR_MAGIC_DEFAULT = 4'hA;

  localparam int HDR_MAGIC_MSB = 7;
  localparam int HDR_MAGIC_LSB = 4;
  localparam int HDR_ID_MSB    = 1;
  localparam int HDR_ID_LSB    = 0;

  // Bits [3:2] of the header are reserved and always zero.
  function automatic logic [7:0] make_header(input logic [3:0] magic, input logic [1:0] id);
    logic [7:0] hdr;
    hdr = '0;
    hdr[HDR_MAGIC_MSB:HDR_MAGIC_LSB] = magic;
    hdr[HDR_ID_MSB:HDR_ID_LSB]       = id;
    return hdr;
  endfunction

endpackage

// File: rtl/uart_stream_arbiter_rr_picker.sv
// Combinational round-robin selector: first requester at or after i_rr_ptr,
// wrapping modulo NUM_SRC.
module rr_picker #(
  parameter int NUM_SRC = 2
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [1:0]         i_rr_ptr,
  output logic [1:0]         o_winner,
  output logic               o_any_req
);

  int w_idx;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    o_winner  = '0;
    o_any_req = |i_req;
    w_idx     = 0;
    // Walk from the farthest candidate back to rr_ptr so the nearest requester is written last.
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      w_idx = int'(i_rr_ptr) + k;
      if (w_idx >= NUM_SRC) w_idx = w_idx - NUM_SRC;
      if (i_req[w_idx]) o_winner = 2'(w_idx);
    end
  end

endmodule

// File: rtl/uart_stream_arbiter.sv
// Round-robin framer sharing one UART byte input between NUM_SRC streams.
// Define UART_ARB_CHECKSUM_EN to append an XOR checksum trailer to every burst.
module uart_stream_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         NUM_SRC   = 2,
  parameter int         BURST_LEN = 16,
  parameter logic [3:0] HDR_MAGIC = HDR_MAGIC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*NUM_SRC-1:0]   src_data,
  input  logic [NUM_SRC-1:0]     src_valid,
  output logic [NUM_SRC-1:0]     src_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [1:0]             grant_id,
  output logic                   busy
);

  localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

  arb_state_e r_state;
  arb_state_e w_state_next;
  logic [1:0] r_grant_id;
  logic [1:0] r_rr_ptr;
  logic [7:0] r_byte_cnt;
  logic [1:0] w_winner;
  logic [1:0] w_rr_next;
  logic       w_any_req;
  logic       w_sel_valid;
  logic [7:0] w_sel_data;
  logic       w_tx_fire;
  logic       w_last_byte;
`ifdef UART_ARB_CHECKSUM_EN
  logic [7:0] r_checksum;
`endif

  rr_picker #(.NUM_SRC(NUM_SRC)) u_rr_picker (
    .i_req     (src_valid),
    .i_rr_ptr  (r_rr_ptr),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    src_ready   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant_id == 2'(i)) begin
        w_sel_valid  = src_valid[i];
        w_sel_data   = src_data[8*i +: 8];
        src_ready[i] = (r_state == PAYLOAD) && tx_ready;
      end
    end
  end

  assign w_tx_fire   = tx_valid && tx_ready;
  assign w_last_byte = (r_state == PAYLOAD) && w_tx_fire && (r_byte_cnt == LAST_IDX);
  assign w_rr_next   = (r_grant_id == 2'(NUM_SRC - 1)) ? 2'b00 : r_grant_id + 2'd1;

  always_comb begin
    w_state_next = r_state;
    tx_valid     = 1'b0;
    tx_data      = '0;
    case (r_state)
      IDLE: begin
        if (w_any_req) w_state_next = HEADER;
      end
      HEADER: begin
        tx_valid = 1'b1;
        tx_data  = make_header(HDR_MAGIC, r_grant_id);
        if (tx_ready) w_state_next = PAYLOAD;
      end
      PAYLOAD: begin
        tx_valid = w_sel_valid;
        tx_data  = w_sel_data;
`ifdef UART_ARB_CHECKSUM_EN
        if (w_last_byte) w_state_next = TRAILER;
`else
        if (w_last_byte) w_state_next = IDLE;
`endif
      end
`ifdef UART_ARB_CHECKSUM_EN
      TRAILER: begin
        tx_valid = 1'b1;
        tx_data  = r_checksum;
        if (tx_ready) w_state_next = IDLE;
      end
`endif
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_any_req) r_grant_id <= w_winner;
      if (r_state == HEADER && tx_ready) begin
        r_byte_cnt <= '0;
      end else if (r_state == PAYLOAD && w_tx_fire) begin
        r_byte_cnt <= r_byte_cnt + 8'd1;
      end
      // The source just served drops to lowest priority for the next arbitration.
      if (w_last_byte) r_rr_ptr <= w_rr_next;
    end
  end

`ifdef UART_ARB_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (r_state == HEADER && tx_ready) begin
      r_checksum <= '0;
    end else if (r_state == PAYLOAD && w_tx_fire) begin
      r_checksum <= r_checksum ^ w_sel_data;
    end
  end
`endif

  assign grant_id = r_grant_id;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_uart_stream_arbiter.sv
// Scoreboard bench for uart_stream_arbiter: expected frames are queued by the
// stimulus and popped by a monitor on every tx transfer.
module tb_uart_stream_arbiter;

  localparam int NS  = 2;
  localparam int BL  = 8;
  localparam int BL1 = 3;
`ifdef UART_ARB_CHECKSUM_EN
  localparam int FRAME1 = BL1 + 2;
`else
  localparam int FRAME1 = BL1 + 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, rst1_n;
  logic [7:0]      src_byte [NS];
  logic [8*NS-1:0] src_data;
  logic [NS-1:0]   src_valid, src_ready;
  logic [7:0]      tx_data;
  logic            tx_valid, tx_ready;
  logic [1:0]      grant_id;
  logic            busy;

  logic [7:0] src1_data;
  logic [0:0] src1_valid, src1_ready;
  logic [7:0] tx1_data;
  logic       tx1_valid, tx1_ready;
  logic [1:0] grant1_id;
  logic       busy1;

  assign src_data  = {src_byte[1], src_byte[0]};
  assign src1_data = 8'h5C;

  uart_stream_arbiter #(.NUM_SRC(NS), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy)
  );

  uart_stream_arbiter #(.NUM_SRC(1), .BURST_LEN(BL1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .src_data(src1_data), .src_valid(src1_valid),
    .src_ready(src1_ready), .tx_data(tx1_data), .tx_valid(tx1_valid),
    .tx_ready(tx1_ready), .grant_id(grant1_id), .busy(busy1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  // ---------------- scoreboard and monitor ----------------
  logic [7:0] exp_q [$];
  logic [7:0] exp_next [NS];
  logic [NS-1:0] took = '0;
  int ready_cnt [NS] = '{0, 0};
  int xfer_cnt  [NS] = '{0, 0};
  logic hold_chk_en = 1'b0;
  logic held_pending = 1'b0;
  logic [7:0] held_data;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) fail("tx_unexpected_byte");
        else check("tx_byte", tx_data, exp_q.pop_front());
      end
      took = src_valid & src_ready;
      for (int i = 0; i < NS; i++) begin
        ready_cnt[i] += int'(src_ready[i]);
        xfer_cnt[i]  += int'(took[i]);
      end
      if (hold_chk_en) begin
        if (held_pending) begin
          check("hold_valid", tx_valid, 1'b1);
          check("hold_data", tx_data, held_data);
        end
        held_pending = tx_valid && !tx_ready;
        held_data    = tx_data;
      end else begin
        held_pending = 1'b0;
      end
    end else begin
      took = '0;
    end
  end

  // Single-source instance: header on every frame boundary, fixed frame period.
  int cyc1 = 0, idx1 = 0, last_hdr1 = -1, nhdr1 = 0;
  always @(negedge clk) begin
    if (rst1_n) begin
      cyc1++;
      if (tx1_valid && tx1_ready) begin
        if (idx1 % FRAME1 == 0) begin
          check("n1_header", tx1_data, 8'hA0);
          if (last_hdr1 >= 0) check("n1_period", cyc1 - last_hdr1, FRAME1 + 1);
          last_hdr1 = cyc1;
          nhdr1++;
        end else begin
          // Payload is constant 5C; XOR of three 5C bytes is also 5C.
          check("n1_payload", tx1_data, 8'h5C);
        end
        idx1++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) if (took[i]) src_byte[i] = src_byte[i] + 8'd1;
  endtask

  task automatic push_burst(input int id);
    logic [7:0] cs;
    cs = '0;
    exp_q.push_back(8'hA0 | 8'(id));
    for (int k = 0; k < BL; k++) begin
      exp_q.push_back(exp_next[id]);
      cs = cs ^ exp_next[id];
      exp_next[id] = exp_next[id] + 8'd1;
    end
`ifdef UART_ARB_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      fail(name);
      exp_q.delete();
    end
  endtask

  task automatic wait_xfer(input string name, input int id, input int count, input int budget);
    int base, n;
    base = xfer_cnt[id];
    n = 0;
    while (xfer_cnt[id] - base < count && n < budget) begin
      tick();
      n++;
    end
    if (xfer_cnt[id] - base < count) fail(name);
  endtask

  int r0, x0, x1, n;

  initial begin
    rst_n = 1'b0; rst1_n = 1'b0;
    src_valid = '0; tx_ready = 1'b0;
    src1_valid = '0; tx1_ready = 1'b0;
    src_byte[0] = 8'h10; src_byte[1] = 8'h01;
    exp_next[0] = 8'h10; exp_next[1] = 8'h01;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant_id, 2'd0);
    check("rst_src_ready", src_ready, 2'b00);

    // Source 1 alone: A1, 01..08 (+ checksum 08).
    tx_ready = 1'b1;
    push_burst(1);
    src_valid = 2'b10;
    drain("s2_drain", 100);
    src_valid = 2'b00;
    check("s2_ready0", ready_cnt[0], 0);
    check("s2_xfer1", xfer_cnt[1], BL);
    tick();
    check("s2_idle", busy, 1'b0);

    // Both sources valid with rr_ptr back at 0: A0, A1, A0, A1.
    x0 = xfer_cnt[0]; x1 = xfer_cnt[1];
    push_burst(0); push_burst(1); push_burst(0); push_burst(1);
    src_valid = 2'b11;
    drain("s3_drain", 400);
    src_valid = 2'b00;
    check("s3_xfer0", xfer_cnt[0] - x0, 2 * BL);
    check("s3_xfer1", xfer_cnt[1] - x1, 2 * BL);
    tick();

    // tx_ready toggling every cycle; held bytes must stay stable.
    push_burst(0);
    hold_chk_en = 1'b1;
    src_valid = 2'b01;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tx_ready = ~tx_ready;
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      fail("s4_drain");
      exp_q.delete();
    end
    hold_chk_en = 1'b0;
    src_valid = 2'b00;
    tx_ready = 1'b1;
    tick();

    // rr_ptr now 1: source 1 wins, stalls 10 cycles mid-burst while source 0 waits.
    x0 = xfer_cnt[0]; x1 = xfer_cnt[1];
    push_burst(1); push_burst(0);
    src_valid = 2'b11;
    wait_xfer("s5_first_bytes", 1, 2, 50);
    src_valid = 2'b01;
    r0 = ready_cnt[0];
    repeat (10) tick();
    check("s5_no_ready0", ready_cnt[0] - r0, 0);
    check("s5_busy", busy, 1'b1);
    check("s5_grant", grant_id, 2'd1);
    src_valid = 2'b11;
    drain("s5_drain", 200);
    src_valid = 2'b00;
    check("s5_xfer1", xfer_cnt[1] - x1, BL);
    check("s5_xfer0", xfer_cnt[0] - x0, BL);
    tick();

    // Reset during PAYLOAD with byte_cnt=5 abandons the burst.
    push_burst(1);
    src_valid = 2'b10;
    wait_xfer("s6_five_bytes", 1, 5, 50);
    rst_n = 1'b0;
    src_valid = 2'b00;
    tick();
    check("s6_tx_valid", tx_valid, 1'b0);
    check("s6_busy", busy, 1'b0);
    check("s6_grant", grant_id, 2'd0);
    check("s6_src_ready", src_ready, 2'b00);
    exp_q.delete();
    exp_next[1] = exp_next[1] - 8'(BL - 5);
    rst_n = 1'b1;
    tick();
    push_burst(1);
    src_valid = 2'b10;
    drain("s6_drain", 100);
    src_valid = 2'b00;
    repeat (3) tick();

    // Single-source instance, continuously valid.
    rst1_n = 1'b1;
    tx1_ready = 1'b1;
    src1_valid = 1'b1;
    repeat (4 * (FRAME1 + 1) + 2) tick();
    check("n1_frames", nhdr1 >= 4, 1'b1);
    src1_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
